// File: rtl/sliding_pattern.sv
// Streams a per-pixel mask by repeating a 32-bit pattern along each row, sliding one position per row.
// Optional macro SLIDING_PATTERN_FRAME_RESYNC_EN restarts the slide offset at every frame wrap.
module sliding_pattern #(
    parameter int unsigned image_sensor_w = 35,
    parameter int unsigned image_sensor_h = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [0:31] pattern,
    input  logic        right_sliding,
    input  logic        load_pattern,
    output logic        rp_mask_bit,
    output logic        rp_valid
);

    localparam int unsigned XW = (image_sensor_w > 1) ? $clog2(image_sensor_w) : 1;
    localparam int unsigned YW = (image_sensor_h > 1) ? $clog2(image_sensor_h) : 1;
    localparam int unsigned PW = 5;

    logic [0:31]   pat_reg;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW-1:0] off;
    logic [PW-1:0] phase;
    logic          active;

    logic          row_end_c;
    logic          frame_end_c;
    logic [PW-1:0] off_n_c;

    // Row/frame boundary detection and next-row offset
    always_comb begin
        row_end_c   = (x == XW'(image_sensor_w - 1));
        frame_end_c = row_end_c && (y == YW'(image_sensor_h - 1));
        off_n_c     = right_sliding ? (off - PW'(1)) : (off + PW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg     <= '0;
            x           <= '0;
            y           <= '0;
            off         <= '0;
            phase       <= '0;
            active      <= 1'b0;
            rp_mask_bit <= 1'b0;
            rp_valid    <= 1'b0;
        end else if (!clk_en) begin
            rp_valid <= 1'b0;
        end else if (load_pattern) begin
            pat_reg  <= pattern;
            x        <= '0;
            y        <= '0;
            off      <= '0;
            phase    <= '0;
            active   <= 1'b1;
            rp_valid <= 1'b0;
        end else if (active) begin
            rp_mask_bit <= pat_reg[phase];
            rp_valid    <= 1'b1;
            if (!row_end_c) begin
                x     <= x + XW'(1);
                phase <= phase + PW'(1);
            end else begin
                x <= '0;
                y <= frame_end_c ? '0 : (y + YW'(1));
`ifdef SLIDING_PATTERN_FRAME_RESYNC_EN
                // Every frame restarts from the unslid pattern
                off   <= frame_end_c ? '0 : off_n_c;
                phase <= frame_end_c ? '0 : off_n_c;
`else
                off   <= off_n_c;
                phase <= off_n_c;
`endif
            end
        end else begin
            rp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_pattern.sv
// Scoreboard bench for sliding_pattern: stimulus pushes expected bits, a monitor pops them on rp_valid.
module tb_sliding_pattern;

    localparam int unsigned W = 35;
    localparam int unsigned H = 35;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [0:31] pattern;
    logic        right_sliding;
    logic        load_pattern;
    logic        rp_mask_bit;
    logic        rp_valid;

    sliding_pattern #(.image_sensor_w(W), .image_sensor_h(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .pattern       (pattern),
        .right_sliding (right_sliding),
        .load_pattern  (load_pattern),
        .rp_mask_bit   (rp_mask_bit),
        .rp_valid      (rp_valid)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic log_q[$];

    // Reference state: pixel (x,y) = pat[(x + off) mod 32], off per row
    logic [0:31] m_pat = '0;
    int          m_x = 0, m_y = 0, m_off = 0;
    bit          m_active = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic log_at(input int idx);
        if (idx < 0 || idx >= log_q.size()) return 1'bx;
        return log_q[idx];
    endfunction

    // Monitor: every valid pixel must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel: got bit %b with no pixel expected", rp_mask_bit);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (rp_mask_bit !== e) begin
                    errors++;
                    $display("FAIL pixel_%0d: got %b expected %b", log_q.size(), rp_mask_bit, e);
                end
            end
            log_q.push_back(rp_mask_bit);
        end
    end

    task automatic step(input bit en, input bit ld, input bit dir, input logic [0:31] p);
        clk_en        = en;
        load_pattern  = ld;
        right_sliding = dir;
        pattern       = p;
        if (en) begin
            if (ld) begin
                m_pat = p; m_x = 0; m_y = 0; m_off = 0; m_active = 1'b1;
            end else if (m_active) begin
                exp_q.push_back(m_pat[(m_x + m_off) % 32]);
                if (m_x < int'(W) - 1) begin
                    m_x++;
                end else begin
                    m_x = 0;
                    m_off = dir ? (m_off + 31) % 32 : (m_off + 1) % 32;
                    if (m_y == int'(H) - 1) begin
                        m_y = 0;
`ifdef SLIDING_PATTERN_FRAME_RESYNC_EN
                        m_off = 0;
`endif
                    end else begin
                        m_y++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; clk_en = 1'b1; load_pattern = 1'b0; right_sliding = 1'b0; pattern = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", rp_valid, 1'b0);
        check("reset_bit", rp_mask_bit, 1'b0);
        rst = 1'b0;
        // Idle without load: nothing may be emitted
        repeat (4) step(1, 0, 0, '0);
        check("idle_valid", rp_valid, 1'b0);

        // Pattern 7, left slide, switch to right after 50 pixels
        step(1, 1, 0, 32'd7);
        check("load_bubble", rp_valid, 1'b0);
        base = log_q.size();
        step(1, 0, 0, '0);
        check("first_pixel_valid", rp_valid, 1'b1);
        repeat (49) step(1, 0, 0, '0);
        repeat (4 * W - 50) step(1, 0, 1, '0);
        step(1, 0, 1, '0);
        check("r0_x28", log_at(base + 28), 1'b0);
        check("r0_x29", log_at(base + 29), 1'b1);
        check("r0_x31", log_at(base + 31), 1'b1);
        check("r0_x32", log_at(base + 32), 1'b0);
        check("r1_x28", log_at(base + W + 28), 1'b1);
        check("r1_x31", log_at(base + W + 31), 1'b0);
        check("r2_x28", log_at(base + 2 * W + 28), 1'b0);
        check("r2_x31", log_at(base + 2 * W + 31), 1'b1);
        check("r3_x0", log_at(base + 3 * W + 0), 1'b1);
        check("r3_x29", log_at(base + 3 * W + 29), 1'b0);
        check("r3_x32", log_at(base + 3 * W + 32), 1'b1);

        // Frame wrap: one full frame, then frame 2 row 0 with clk_en toggling
        step(1, 1, 0, 32'd7);
        base = log_q.size();
        repeat (W * H) step(1, 0, 0, '0);
        repeat (W) begin
            step(0, 0, 0, '0);
            check("gated_valid", rp_valid, 1'b0);
            step(1, 0, 0, '0);
        end
        step(0, 0, 0, '0);
`ifdef SLIDING_PATTERN_FRAME_RESYNC_EN
        check("f2_x26", log_at(base + W * H + 26), 1'b0);
        check("f2_x29", log_at(base + W * H + 29), 1'b1);
`else
        check("f2_x26", log_at(base + W * H + 26), 1'b1);
        check("f2_x29", log_at(base + W * H + 29), 1'b0);
`endif

        // Mid-frame reload, load held high for several cycles
        repeat (10) step(1, 0, 0, '0);
        repeat (3) step(1, 1, 0, 32'h8000_0001);
        check("held_load_valid", rp_valid, 1'b0);
        base = log_q.size();
        repeat (W) step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        check("reload_x0", log_at(base + 0), 1'b1);
        check("reload_x1", log_at(base + 1), 1'b0);
        check("reload_x31", log_at(base + 31), 1'b1);
        check("reload_x32", log_at(base + 32), 1'b1);

        repeat (3) step(0, 0, 0, '0);
        check("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound the run in case stimulus stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sliding_pattern.md
Name: sliding_pattern

Overview:
- Generates a per-pixel binary mask stream for a W x H image-sensor frame by repeating a 32-bit pattern across each row.
- Each new row is the previous row's pattern slid by one position, left or right.
- Pattern and direction are written by the micro-processor; one mask bit is emitted per enabled clock, in raster order, to the pixel-masking datapath.

Parameters:
- image_sensor_w, 35, pixels per row (>=1)
- image_sensor_h, 35, rows per frame (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  clock enable; all state except rp_valid advances only when 1
- pattern  input  [0:31]  repeated pattern; index 0 is the MSB
- right_sliding  input  1  slide direction: 1 = right, 0 = left
- load_pattern  input  1  load pattern and restart the frame
- rp_mask_bit  output  1  mask bit for the current pixel (registered)
- rp_valid  output  1  rp_mask_bit holds a new pixel this cycle (registered)

Behaviour:
- Reset, when rst=1 at a rising edge, regardless of clk_en:
  - pat_reg=0, x=0, y=0, off=0, phase=0, active=0
  - rp_mask_bit=0, rp_valid=0
- Counter widths:
  - x: $clog2(image_sensor_w), min 1
  - y: $clog2(image_sensor_h), min 1
  - off and phase: 5 bits, naturally mod 32
- Pixel rule: mask(x,y) = pat_reg[(x + off_y) mod 32], where off_y is the row offset.
  - phase tracks (x + off_y) mod 32 incrementally, so no multiply/divide is needed.
- Load (clk_en=1, load_pattern=1):
  - pat_reg<=pattern, x<=0, y<=0, off<=0, phase<=0, active<=1, rp_valid<=0
  - Load has priority over streaming. Holding load_pattern high keeps restarting and emits nothing.
- Stream (clk_en=1, load_pattern=0, active=1):
  - rp_mask_bit<=pat_reg[phase], rp_valid<=1, then advance.
  - x<W-1: x<=x+1, phase<=phase+1.
  - x=W-1 (row end): x<=0, y<=(y==H-1)?0:y+1.
  - At row end the new offset is off_n = right_sliding ? off-1 : off+1 (mod 32); off<=off_n, phase<=off_n.
  - right_sliding is sampled only at row ends, so a mid-row change takes effect on the next row.
  - Frame wrap (x=W-1, y=H-1): streaming continues into the next frame with no gap. off keeps sliding (unless the optional feature is enabled).
- clk_en=0: all state and rp_mask_bit hold; rp_valid<=0, so no pixel is counted twice.
- Idle (active=0, no load): rp_valid<=0, rp_mask_bit holds.
- Latency: load sampled at edge k; pixel (0,0) appears after edge k+1; one pixel per enabled cycle thereafter.
- Throughput: W*H enabled cycles per frame, with no bubbles at row or frame boundaries.

Optional Feature:
- Macro: SLIDING_PATTERN_FRAME_RESYNC_EN
- Defined: at frame wrap, off<=0 and phase<=0. Every frame is identical and starts at the unslid pattern.
- Undefined: off continues sliding across frame boundaries (default behaviour above).

Test Plan:
- Reset: rst=1 for 2 cycles with clk_en=1 -> rp_valid=0, rp_mask_bit=0; nothing is emitted until load_pattern.
- Load pattern=32'd7 (ones at indices 29..31), right_sliding=0:
  - row 0: ones only at x=29,30,31; x=32..34 = 0 (wrapped indices 0..2)
  - row 1: ones at x=28,29,30
  - row 2: ones at x=27,28,29
  - rp_valid high continuously from cycle k+1.
- Switch right_sliding=1 mid-row after 50 cycles:
  - the current row is unchanged
  - the next row's ones shift +1 column relative to the current row
  - offset wraps 0->31 correctly.
- clk_en toggled 1/0 every cycle during streaming -> rp_valid pulses only on enabled cycles; the bit sequence equals the continuous-clk_en sequence.
- Frame wrap, W=H=35: after 1225 valid pixels, pixel (0,0) of frame 2 has off=35 mod 32=3 (left sliding). With SLIDING_PATTERN_FRAME_RESYNC_EN, frame 2 equals frame 1 exactly.
- Reload mid-frame with pattern=32'h8000_0001 -> the next pixel after the load bubble is pattern[0]=1 at (0,0), and x=31 is 1.
